// File: rtl/mult_seq_ctrl.sv
// Sequencing controller for a shift-add multiplier datapath: job handshake plus
// per-cycle A/Q/P select codes, with early exit once the remaining multiplier is zero.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             q_lsb,
    input  logic             q_zero,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       a_sel,
    output logic [1:0]       q_sel,
    output logic [1:0]       p_sel,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_t;

    localparam logic [1:0] SelHold  = 2'b00;
    localparam logic [1:0] SelLoad  = 2'b01;
    localparam logic [1:0] SelShift = 2'b10;
    localparam logic [1:0] SelClear = 2'b01;
    localparam logic [1:0] SelAdd   = 2'b10;

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MaxIter  = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        a_sel   = SelHold;
        q_sel   = SelHold;
        p_sel   = SelHold;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    a_sel   = SelLoad;
                    q_sel   = SelLoad;
                    p_sel   = SelClear;
                    iter_d  = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (q_zero) begin
                    // Remaining multiplier is zero: P already holds the product.
                    state_d = StDone;
                end else begin
                    a_sel = SelShift;
                    q_sel = SelShift;
                    p_sel = q_lsb ? SelAdd : SelHold;
                    if (iter_q != MaxIter) begin
                        iter_d = iter_q + 1'b1;
                    end
                    if (iter_q == LastIter) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign iter = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a job-phase model checked every cycle, a Q shadow
// emulating the datapath, and directed jobs with hand-computed latencies.
module tb_mult_seq_ctrl;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          q_lsb, q_zero;
    logic          ready, busy, done;
    logic [1:0]    a_sel, q_sel, p_sel;
    logic [CW-1:0] iter;

    mult_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .abort  (abort),
        .q_lsb  (q_lsb),
        .q_zero (q_zero),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .a_sel  (a_sel),
        .q_sel  (q_sel),
        .p_sel  (p_sel),
        .iter   (iter)
    );

    always #5 clk = ~clk;

    // Datapath Q register shadow
    logic [W-1:0] operand = '0;
    logic [W-1:0] q_sh = '0;
    assign q_lsb  = q_sh[0];
    assign q_zero = (q_sh == '0);
    always @(posedge clk) begin
        if (q_sel == 2'b01)      q_sh <= operand;
        else if (q_sel == 2'b10) q_sh <= q_sh >> 1;
    end

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Shifting iterations a multiplier needs: index of its top set bit + 1.
    function automatic int iters_of(input logic [W-1:0] m);
        int n = 0;
        for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    // Job model: phase 1 = load, phases 2..k+1 = calc, phase k+2 = done.
    bit           m_busy = 1'b0;
    int           phase = 0;
    int           n_it = 0;
    int           k = 0;
    int           m_iter = 0;
    logic [W-1:0] mult = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            phase  <= 0;
            m_iter <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                phase  <= 1;
                mult   <= operand;
                n_it   <= iters_of(operand);
                k      <= (iters_of(operand) == W) ? W : iters_of(operand) + 1;
            end
        end else if (phase == 1) begin
            if (abort) m_busy <= 1'b0;
            else begin
                m_iter <= 0;
                phase  <= 2;
            end
        end else if (phase <= k + 1) begin
            if (abort) m_busy <= 1'b0;
            else begin
                if (phase - 2 < n_it) m_iter <= phase - 1;
                phase <= phase + 1;
            end
        end else begin
            m_busy <= 1'b0;
        end
    end

    logic       e_ready, e_busy, e_done;
    logic [1:0] e_a, e_q, e_p;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (chk_en) begin
            e_ready = !m_busy;
            e_busy  = 1'b0;
            e_done  = 1'b0;
            e_a = 2'b00;
            e_q = 2'b00;
            e_p = 2'b00;
            if (m_busy && phase == 1) begin
                e_busy = 1'b1;
                if (!abort) begin
                    e_a = 2'b01;
                    e_q = 2'b01;
                    e_p = 2'b01;
                end
            end else if (m_busy && phase <= k + 1) begin
                e_busy = 1'b1;
                if (!abort && (phase - 2) < n_it) begin
                    e_a = 2'b10;
                    e_q = 2'b10;
                    e_p = mult[phase-2] ? 2'b10 : 2'b00;
                end
            end else if (m_busy) begin
                e_done = 1'b1;
            end
            chk("ready", 32'(ready), 32'(e_ready));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("a_sel", 32'(a_sel), 32'(e_a));
            chk("q_sel", 32'(q_sel), 32'(e_q));
            chk("p_sel", 32'(p_sel), 32'(e_p));
            chk("iter", 32'(iter), 32'(m_iter));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ptrace [0:63];

    // Start a job and wait (bounded) for done; latency counts cycles from the accepting edge.
    task automatic run_job(input logic [W-1:0] op, input logic ab, output int lat,
                           output int it);
        operand = op;
        start   = 1'b1;
        abort   = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
        lat   = -1;
        it    = -1;
        for (int n = 1; n < 64; n++) begin
            ptrace[n] = p_sel;
            if (done === 1'b1) begin
                lat = n;
                it  = int'(iter);
                break;
            end
            tick();
        end
        tick();
    endtask

    int lat, it, cnt, dc0;

    initial begin
        tick();
        tick();
        chk_en = 1'b1;
        reset  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_sel", 32'({a_sel, q_sel, p_sel}), 32'd0);
            chk("rst_iter", 32'(iter), 32'd0);
        end

        run_job(32'h5, 1'b0, lat, it);
        chk("x5_latency", 32'(lat), 32'd6);
        chk("x5_iter", 32'(it), 32'd3);
        chk("x5_p_load", 32'(ptrace[1]), 32'd1);
        chk("x5_p_c1", 32'(ptrace[2]), 32'd2);
        chk("x5_p_c2", 32'(ptrace[3]), 32'd0);
        chk("x5_p_c3", 32'(ptrace[4]), 32'd2);
        chk("x5_p_c4", 32'(ptrace[5]), 32'd0);
        chk("x5_ready_after", 32'(ready), 32'd1);

        run_job(32'hFFFF_FFFF, 1'b0, lat, it);
        cnt = 0;
        for (int n = 2; n <= 33; n++) if (ptrace[n] == 2'b10) cnt++;
        chk("full_latency", 32'(lat), 32'd34);
        chk("full_iter", 32'(it), 32'd32);
        chk("full_adds", 32'(cnt), 32'd32);
        chk("full_ready_after", 32'(ready), 32'd1);

        run_job(32'h0, 1'b0, lat, it);
        chk("zero_latency", 32'(lat), 32'd3);
        chk("zero_iter", 32'(it), 32'd0);
        chk("zero_p_calc", 32'(ptrace[2]), 32'd0);

        // Abort in the 5th CALC cycle of a full-width job
        dc0     = done_cnt;
        operand = 32'hFFFF_FFFF;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_iter", 32'(iter), 32'd4);
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_done", 32'(done_cnt), 32'(dc0));
        run_job(32'h3, 1'b0, lat, it);
        chk("post_abort_latency", 32'(lat), 32'd5);
        chk("post_abort_iter", 32'(it), 32'd2);

        // start and abort together in IDLE: start wins
        run_job(32'h1, 1'b1, lat, it);
        chk("start_abort_latency", 32'(lat), 32'd4);
        chk("start_abort_iter", 32'(it), 32'd1);

        // start held high across jobs, reset mid-CALC of the second
        dc0     = done_cnt;
        operand = 32'h3;
        start   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("held_done1", 32'(done), 32'd1);
        tick();
        chk("held_idle", 32'(ready), 32'd1);
        tick();
        chk("held_load2", 32'(a_sel), 32'd1);
        tick();
        tick();
        chk("held_calc_iter", 32'(iter), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("held_rst_ready", 32'(ready), 32'd1);
        chk("held_rst_iter", 32'(iter), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("held_one_done", 32'(done_cnt), 32'(dc0 + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencing controller for the shift-add multiplier datapath. The datapath has a multiplicand register A (shift left), a multiplier register Q (shift right) and a product accumulator P. The block gives the multiplier a start/ready/done job handshake and drives per-cycle select codes for A, Q and P. It counts iterations internally and terminates early once the remaining multiplier is zero.

Parameters:
WIDTH, 32, operand width; maximum number of add/shift iterations
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  job request; accepted only when ready=1
abort  in  1  cancels an in-flight job; returns to IDLE without done
q_lsb  in  1  bit 0 of datapath Q register
q_zero  in  1  datapath Q register == 0
ready  out  1  high in IDLE only
busy  out  1  high in LOAD and CALC
done  out  1  one-cycle pulse, job complete, P valid
a_sel  out  2  00 hold, 01 load operand, 10 shift left, 11 reserved (never driven)
q_sel  out  2  00 hold, 01 load operand, 10 shift right, 11 reserved
p_sel  out  2  00 hold, 01 clear, 10 add A, 11 reserved
iter  out  CNT_W  completed add/shift iterations of the current or last job

Behaviour:
- States: IDLE, LOAD, CALC, DONE. Registered Moore state; selects are combinational from state, q_lsb and q_zero.
- Reset (synchronous, dominates all inputs):
  - state=IDLE, iter=0.
  - Outputs: ready=1, busy=0, done=0, all selects=00.
- IDLE:
  - ready=1, selects=00.
  - start=1 at a clock edge moves to LOAD.
  - start is ignored in every other state (no queuing).
- LOAD (1 cycle):
  - a_sel=01, q_sel=01, p_sel=01; iter cleared to 0.
  - Next state: CALC.
- CALC, one iteration per cycle:
  - If q_zero=1: all selects=00, next DONE. This is early exit; iter is not incremented.
  - Else: a_sel=10, q_sel=10, p_sel = q_lsb ? 10 : 00. The datapath adds the pre-shift A in the same edge. iter increments.
  - If iter == WIDTH-1 during that cycle, next state is DONE; otherwise stay in CALC.
- DONE (1 cycle):
  - done=1, selects=00, iter held.
  - Next state: IDLE. ready rises the cycle after done.
- Latency: with k = number of CALC cycles (k ≤ WIDTH), done is asserted k+2 cycles after the accepting edge.
  - Full-width job: k=WIDTH (34 cycles at WIDTH=32).
  - Early exit: k = index of the highest set multiplier bit + 2.
- abort:
  - In LOAD or CALC: next state IDLE, selects forced to 00 that cycle, no done pulse, iter held.
  - In IDLE or DONE: ignored; DONE still pulses.
- Simultaneous events:
  - reset beats abort; abort beats the CALC transition.
  - start together with abort in IDLE: start wins, because abort is ignored there.
- Multiplier = 0: CALC sees q_zero=1 in its first cycle, so k=1 and done comes 3 cycles after accept. P stays cleared.
- iter never exceeds WIDTH; it does not wrap.
- Select code 11 is never driven on any output.

Test Plan:
- Reset held 2 cycles, then released with start=0 -> ready=1, busy=0, done=0, selects=00, iter=0, steady for 10 cycles.
- Multiplier 0x00000005 (q_lsb/q_zero model follows a Q shadow), start pulse -> LOAD (01/01/01), then CALC p_sel sequence 10, 00, 10, then a q_zero hold cycle; done at accept+6, iter=3.
- Multiplier 0xFFFFFFFF, WIDTH=32 -> 32 CALC cycles all with p_sel=10; done at accept+34, iter=32, then ready=1 the following cycle.
- Multiplier 0 -> single CALC cycle with selects=00; done at accept+3, iter=0.
- abort asserted in the 5th CALC cycle of a 0xFFFFFFFF job -> next cycle IDLE, ready=1, no done pulse ever, iter=4. A new start is then accepted normally.
- start held high continuously across two jobs, plus reset asserted mid-CALC -> a second job starts only after DONE→IDLE. Reset yields IDLE, iter=0 and no done pulse.
